alu_mul_seq: RTL



---
 rtl/alu_mul_seq.sv | 119 +++++++++++
 1 files changed

// File: rtl/alu_mul_seq.sv
// Shift-and-add 4-bit multiplier sequenced over an external combinational ALU.
// It issues only ALU add (f=0) and double (f=2); the product is (A*B) mod 16.
module alu_mul_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_p,
  output logic [3:0] alu_x,
  output logic [3:0] alu_y,
  output logic [1:0] alu_f,
  input  logic [3:0] alu_xy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DBL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state, state_next;
  logic [3:0] acc, mcand, mplier;
  logic [1:0] idx;
  logic [2:0] j;
  logic [3:0] rest;

  // j is the multiplier bit position that the next step will look at.
  assign j     = {1'b0, idx} + 3'd1;
  assign rest  = mplier >> j;
  assign out_p = acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    alu_x      = 4'd0;
    alu_y      = 4'd0;
    alu_f      = 2'd3;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_b == 4'd0) begin
            state_next = DONE;
          end else if (in_b[0]) begin
            state_next = ADD;
          end else begin
            state_next = DBL;
          end
        end
      end
      ADD: begin
        alu_x      = acc;
        alu_y      = mcand;
        alu_f      = 2'd0;
        state_next = (rest == 4'd0) ? DONE : DBL;
      end
      DBL: begin
        alu_x = mcand;
        alu_f = 2'd2;
        // idx never exceeds 2 here, so j[1:0] is a valid bit index.
        if (mplier[j[1:0]]) begin
          state_next = ADD;
        end else if (rest == 4'd0) begin
          state_next = DONE;
        end else begin
          state_next = DBL;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= 4'd0;
      mcand  <= 4'd0;
      mplier <= 4'd0;
      idx    <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= in_a;
            mplier <= in_b;
            acc    <= 4'd0;
            idx    <= 2'd0;
          end
        end
        ADD: acc <= alu_xy;
        DBL: begin
          mcand <= alu_xy;
          idx   <= idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
